// File: rtl/spi_master_pkg.sv
// Shared types and constants for the 24-bit SPI master engine.
package spi_master_pkg;

  localparam int SPI_DATA_WIDTH     = 24;
  localparam int BIT_CNT_W          = 5;
  localparam int DIV_CNT_W          = 8;
  localparam int GAP_CNT_W          = 8;
  localparam int DEFAULT_CLK_DIV    = 4;
  localparam int DEFAULT_GAP_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_half_tick.sv
// Modulo-DIV half-period counter; o_tick marks the last cycle of each SCLK half-period.
module spi_half_tick
  import spi_master_pkg::*;
#(
  parameter int DIV = DEFAULT_CLK_DIV
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  logic [DIV_CNT_W-1:0] cnt_q;
  logic [DIV_CNT_W-1:0] cnt_d;
  logic                 wrap_s;

  assign wrap_s = (cnt_q == DIV_CNT_W'(DIV - 1));
  assign o_tick = wrap_s;

  // next count: clear restarts the phase so SETUP always lasts a full half-period
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (wrap_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_CNT_W'(1);
    end
  end

  // counter register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_24b.sv
// Mode-0 SPI master: fixed 24-bit frames, one chip select, all pins registered.
// Define SPI_LSB_FIRST_EN for LSB-first shifting in both directions (MSB-first otherwise).
module spi_master_24b
  import spi_master_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_spi_start,
  input  logic [DATA_WIDTH-1:0] i_mosi_data,
  output logic [DATA_WIDTH-1:0] o_miso_data,
  output logic                  o_spi_busy,
  output logic                  o_spi_done,
  output logic                  o_n_cs,
  output logic                  o_spi_clk,
  output logic                  o_spi_mosi,
  input  logic                  i_spi_miso
);

`ifdef SPI_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  spi_state_e            state_q, state_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GAP_CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] miso_data_q, miso_data_d;
  logic                  n_cs_q, n_cs_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  tick_s;
  logic                  tick_clr_s;
  logic [DATA_WIDTH-1:0] rx_shift_s;

  spi_half_tick #(.DIV(CLK_DIV)) u_half_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (tick_clr_s),
    .o_tick (tick_s)
  );

  assign rx_shift_s = LSB_FIRST ? {i_spi_miso, rx_q[DATA_WIDTH-1:1]}
                                : {rx_q[DATA_WIDTH-2:0], i_spi_miso};

  // frame sequencer: every pin is computed here and registered, so SCLK cannot glitch
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    miso_data_d = miso_data_q;
    n_cs_d      = n_cs_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tick_clr_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_spi_start) begin
          state_d    = ST_SETUP;
          tx_d       = i_mosi_data;
          mosi_d     = LSB_FIRST ? i_mosi_data[0] : i_mosi_data[DATA_WIDTH-1];
          n_cs_d     = 1'b0;
          sclk_d     = 1'b0;
          busy_d     = 1'b1;
          bit_cnt_d  = '0;
          tick_clr_s = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_SETUP: begin
        if (tick_s) begin
          state_d = ST_SHIFT;
          sclk_d  = 1'b1;
          rx_d    = rx_shift_s;
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_SHIFT: begin
        if (!tick_s) begin
          state_d = ST_SHIFT;
        end else if (sclk_q) begin
          // falling SCLK: present the next bit for the slave's next rising edge
          sclk_d = 1'b0;
          tx_d   = LSB_FIRST ? {1'b0, tx_q[DATA_WIDTH-1:1]} : {tx_q[DATA_WIDTH-2:0], 1'b0};
          mosi_d = LSB_FIRST ? tx_q[1] : tx_q[DATA_WIDTH-2];
        end else if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
          state_d     = ST_GAP;
          n_cs_d      = 1'b1;
          mosi_d      = 1'b0;
          done_d      = 1'b1;
          miso_data_d = rx_q;
          gap_cnt_d   = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          sclk_d    = 1'b1;
          rx_d      = rx_shift_s;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_CNT_W'(GAP_CYCLES - 1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        n_cs_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // state and output registers; reset discards any partial frame
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      miso_data_q <= '0;
      n_cs_q      <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      miso_data_q <= miso_data_d;
      n_cs_q      <= n_cs_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_miso_data = miso_data_q;
  assign o_spi_busy  = busy_q;
  assign o_spi_done  = done_q;
  assign o_n_cs      = n_cs_q;
  assign o_spi_clk   = sclk_q;
  assign o_spi_mosi  = mosi_q;

endmodule

// File: tb/tb_spi_master_24b.sv
// Self-checking bench: two instances (CLK_DIV=2/GAP=2 and CLK_DIV=5/GAP=3) against a frame-level model.
module tb_spi_master_24b;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic [23:0] data = 24'h0;
  int          mode = 0;
  logic        tb_miso = 1'b0;

  logic [23:0] md2, md5, md;
  logic busy2, busy5, done2, done5, ncs2, ncs5, sclk2, sclk5, mosi2, mosi5;
  logic miso2, miso5, start2, start5;
  logic busy, done, ncs, sclk, mosi;

  int checks = 0;
  int failures = 0;

  assign start2 = start & ~sel;
  assign start5 = start & sel;
  assign miso2  = (mode == 0) ? mosi2 : (mode == 1) ? 1'b1 : tb_miso;
  assign miso5  = (mode == 0) ? mosi5 : (mode == 1) ? 1'b1 : tb_miso;
  assign md     = sel ? md5 : md2;
  assign busy   = sel ? busy5 : busy2;
  assign done   = sel ? done5 : done2;
  assign ncs    = sel ? ncs5 : ncs2;
  assign sclk   = sel ? sclk5 : sclk2;
  assign mosi   = sel ? mosi5 : mosi2;

  spi_master_24b #(.DATA_WIDTH(24), .CLK_DIV(2), .GAP_CYCLES(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_spi_start(start2), .i_mosi_data(data),
    .o_miso_data(md2), .o_spi_busy(busy2), .o_spi_done(done2), .o_n_cs(ncs2),
    .o_spi_clk(sclk2), .o_spi_mosi(mosi2), .i_spi_miso(miso2));

  spi_master_24b #(.DATA_WIDTH(24), .CLK_DIV(5), .GAP_CYCLES(3)) dut5 (
    .i_clk(clk), .i_rst(rst), .i_spi_start(start5), .i_mosi_data(data),
    .o_miso_data(md5), .o_spi_busy(busy5), .o_spi_done(done5), .o_n_cs(ncs5),
    .o_spi_clk(sclk5), .o_spi_mosi(mosi5), .i_spi_miso(miso5));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // word bit index carried by the i-th serial bit of a frame
  function automatic int order(input int i);
`ifdef SPI_LSB_FIRST_EN
    return i;
`else
    return 23 - i;
`endif
  endfunction

  function automatic logic bitv(input logic [23:0] w, input int i);
    return w[order(i)];
  endfunction

  // Issue one frame from an idle cycle and check it against the frame-level model.
  // Returns positioned on the first idle cycle after the gap.
  task automatic run_frame(input logic [23:0] word, input int mmode, input logic [23:0] mword,
                           input int extra_at);
    int D, G, done_cyc, done_cnt, busy_low, rises, bad_edges, bad_runs, run_len;
    int mosi_err, setup_err, idx, cyc;
    logic [23:0] exp_rx;
    logic prev_sclk, prev_ncs;
    bit fin;
    D = sel ? 5 : 2;
    G = sel ? 3 : 2;
    exp_rx = (mmode == 0) ? word : (mmode == 1) ? 24'hFFFFFF : mword;
    done_cyc = 0; done_cnt = 0; busy_low = 0; rises = 0; bad_edges = 0; bad_runs = 0;
    run_len = 0; mosi_err = 0; setup_err = 0; fin = 1'b0;
    prev_sclk = 1'b0; prev_ncs = 1'b1;
    mode = mmode;
    tb_miso = mword[order(0)];
    data = word;
    start = 1'b1;
    cyc = 0;
    while (!fin && cyc < 49 * D + G + 10) begin
      @(negedge clk);
      cyc++;
      start = (cyc == extra_at);
      data  = (cyc == extra_at) ? ~word : word;
      if (cyc == 1) begin
        chk("cs_fall_busy", {ncs, busy}, 2'b01);
        chk("first_mosi", mosi, bitv(word, 0));
      end
      if (cyc <= D && (sclk !== 1'b0 || ncs !== 1'b0)) setup_err++;
      if (sclk && ncs) bad_edges++;
      if (sclk && !prev_sclk && !ncs) rises++;
      idx = sclk ? rises - 1 : rises;
      if (!ncs && idx < 24 && mosi !== bitv(word, idx)) mosi_err++;
      if (!ncs) begin
        if (!prev_ncs && sclk == prev_sclk) run_len++;
        else begin
          if (!prev_ncs && run_len != D) bad_runs++;
          run_len = 1;
        end
      end else if (!prev_ncs) begin
        if (run_len != D) bad_runs++;
        run_len = 0;
      end
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cyc = cyc;
          chk("rx_word", md, exp_rx);
          chk("end_pins", {ncs, mosi}, 2'b10);
        end
      end
      if (done_cyc > 0 && !busy) begin
        busy_low = cyc;
        fin = 1'b1;
      end
      prev_sclk = sclk;
      prev_ncs  = ncs;
      if (rises < 24) tb_miso = mword[order(rises)];
    end
    start = 1'b0;
    chk("done_cycle", done_cyc, 49 * D + 1);
    chk("done_count", done_cnt, 1);
    chk("sclk_rises", rises, 24);
    chk("sclk_outside_cs", bad_edges, 0);
    chk("half_period_len", bad_runs, 0);
    chk("mosi_bits", mosi_err, 0);
    chk("setup_phase", setup_err, 0);
    chk("busy_release", busy_low, done_cyc + G);
  endtask

  initial begin
    logic [23:0] w, mw;
    int dn;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_pins_d2", {ncs2, sclk2, mosi2, busy2, done2}, 5'b10000);
    chk("reset_pins_d5", {ncs5, sclk5, mosi5, busy5, done5}, 5'b10000);
    chk("reset_data_d2", md2, 24'h0);
    chk("reset_data_d5", md5, 24'h0);
    rst = 1'b0;
    @(negedge clk);

    run_frame(24'hA5C3F0, 0, 24'h0, 0);
    run_frame(24'h000000, 1, 24'h0, 0);
    w = 24'($urandom);
    run_frame(w, 0, 24'h0, 40);
    w = 24'($urandom); mw = 24'($urandom);
    run_frame(w, 2, mw, 0);
    run_frame(24'h000001, 0, 24'h0, 0);

    // reset in the middle of a frame
    data = 24'h5A5A5A; mode = 0; start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_pins", {ncs, sclk, mosi, busy, done}, 5'b10000);
    chk("midrst_data", md, 24'h0);
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("start_in_reset", {busy, ncs}, 2'b01);
    dn = 0;
    repeat (120) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("no_done_after_rst", dn, 0);
    run_frame(24'h5A5A5A, 0, 24'h0, 0);

    for (int k = 0; k < 4; k++) begin
      w = 24'($urandom); mw = 24'($urandom);
      run_frame(w, 2, mw, 0);
    end

    sel = 1'b1;
    @(negedge clk);
    run_frame(24'hA5C3F0, 0, 24'h0, 0);
    w = 24'($urandom); mw = 24'($urandom);
    run_frame(w, 2, mw, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master_24b.md
Name: spi_master_24b

Overview:
- SPI master engine on the other end of the front-panel transfer interface.
- Takes a one-cycle start pulse plus a 24-bit word from the front-panel controller and drives n_cs, SCLK and MOSI.
- Captures 24 MISO bits and returns them as a parallel word.
- The front panel gates o_n_cs onto the LCD or switch chip-select externally; this block has one chip-select only.

Parameters:
DATA_WIDTH, 24, bits per transfer (fixed frame, no partial frames)
CLK_DIV, 4, system clocks per SCLK half-period; legal range 2..255
GAP_CYCLES, 4, minimum n_cs-high cycles between frames; legal range 1..255

Ports:
i_clk  in  1  system clock (AXI clock domain)
i_rst  in  1  synchronous, active-high reset
i_spi_start  in  1  one-cycle transfer request
i_mosi_data  in  DATA_WIDTH  word to transmit, latched on accepted start
o_miso_data  out  DATA_WIDTH  last received word, held until next done
o_spi_busy  out  1  high from first cycle after accepted start through end of gap
o_spi_done  out  1  one-cycle pulse at end of frame
o_n_cs  out  1  chip select, active low
o_spi_clk  out  1  SCLK, mode 0 (idles low)
o_spi_mosi  out  1  serial data out
i_spi_miso  in  1  serial data in; synchronous to SCLK, no synchronizer

Behaviour:
- Reset values: o_n_cs=1, o_spi_clk=0, o_spi_mosi=0, o_spi_busy=0, o_spi_done=0, o_miso_data=0.
- Reset mid-frame: all outputs take reset values on the next edge. The partial frame is discarded and no done pulse is issued.
- FSM states: IDLE -> SETUP -> SHIFT -> GAP -> IDLE.
- IDLE:
  - i_spi_start=1 is accepted at edge 0.
  - Shift register loads i_mosi_data.
  - Next state is SETUP.
  - Start while busy is ignored and is not queued.
- SETUP (cycles 1..CLK_DIV, with D=CLK_DIV):
  - n_cs=0, SCLK=0, MOSI = MSB.
  - Provides tCSS of one half-period.
- SHIFT: 24 bits, each 2D cycles.
  - First D cycles: SCLK=1.
  - Next D cycles: SCLK=0.
  - MISO is sampled into the receive shift register on the edge where SCLK rises (first high cycle).
  - MOSI advances to the next bit on the edge where SCLK falls.
  - A 5-bit bit counter counts 0..23.
  - The half-period counter counts 0..D-1 and wraps.
- After bit 23's low half, i.e. at cycle 1+D+48D = 49D+1:
  - n_cs=1, MOSI=0.
  - o_miso_data loads the receive register.
  - o_spi_done=1 for that single cycle.
  - Next state is GAP.
- GAP:
  - GAP_CYCLES cycles with busy=1.
  - Then IDLE with busy=0.
  - The earliest next start is accepted on the first IDLE cycle.
- SCLK never glitches: exactly 24 rising edges per frame, none outside n_cs low.
- Start coincident with reset deassertion: ignored (reset wins on that edge).

Optional Feature:
- SPI_LSB_FIRST_EN
  - Defined: MOSI transmits bit 0 first. Received bits shift in from the MSB end so the first received bit lands in bit 0.
  - Undefined (default): MSB first both directions.
  - Timing is identical in both modes.

Decomposition:
- Package spi_master_pkg:
  - state enum (IDLE, SETUP, SHIFT, GAP)
  - SPI_DATA_WIDTH=24
  - bit-counter width constant
  - default CLK_DIV / GAP_CYCLES constants
- Sub-module spi_half_tick:
  - loadable modulo-CLK_DIV counter
  - outputs tick on wrap
  - cleared by i_rst or on entry to SETUP
- FSM, shift registers and outputs live in the top.

Test Plan:
- CLK_DIV=2, GAP_CYCLES=2, MOSI looped to MISO, start with 0xA5C3F0 -> o_spi_done at cycle 99 after the start edge; o_miso_data=0xA5C3F0; exactly 24 SCLK rising edges counted while n_cs=0.
- MISO tied 1, start with 0x000000 -> MOSI stays 0 all frame; o_miso_data=0xFFFFFF; busy deasserts 2 cycles after done.
- Second start issued at cycle 40 of a frame -> ignored; one done only; first frame data unchanged. Start on first IDLE cycle after gap -> accepted; n_cs falls next cycle.
- Reset asserted at cycle 30 of a frame -> next edge: n_cs=1, SCLK=0, busy=0, o_miso_data=0; no done pulse. New start after release completes normally.
- SPI_LSB_FIRST_EN defined, send 0x000001 with loopback -> first MOSI bit (during SETUP) is 1; o_miso_data=0x000001. Without the macro the first bit is 0.
- CLK_DIV=5 -> SCLK high and low phases each exactly 5 cycles; SETUP 5 cycles; done at cycle 246.
